uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Parametrised full-duplex UART (TX + RX) driven by one shared 16x oversampling tick generator.
- Generalises the fixed 8N2 TX / 8N1 RX pair: configurable data width, stop bits and idle-gap detect; optional parity.
- Adds a valid/ready TX handshake and per-character RX error flags.
- Sits between the CPU's memory-mapped serial register block and the board RS-232 pins.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD, 115200, line bit rate
DATA_BITS, 8, data bits per character, legal 5..9
STOP_BITS, 1, TX stop bits, legal 1 or 2; RX always checks exactly one stop bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined
IDLE_BITS, 16, line-idle bit times after the last stop bit before rx_idle asserts

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tx_valid  in  1  tx_data is offered for transmission
tx_data  in  DATA_BITS  character to send, LSB first
tx_ready  out  1  TX can accept a character this cycle
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous to clk
rx_valid  out  1  one-cycle pulse: character received
rx_data  out  DATA_BITS  received character; held until the next rx_valid
rx_frame_err  out  1  qualified by rx_valid: stop bit sampled low
rx_parity_err  out  1  qualified by rx_valid: parity mismatch; tied 0 when parity is compiled out
rx_idle  out  1  line idle for IDLE_BITS bit times

Behaviour:
- Reset values: tx_ready=1, txd=1, rx_valid=0, rx_data=0, rx_frame_err=0, rx_parity_err=0, rx_idle=0. All counters and FSMs return to IDLE. Reset mid-character aborts the character; txd is forced high the next cycle.

Tick generator:
- Phase accumulator of width ACC_W = clog2(CLK_FREQ/BAUD)+8.
- INC = round(BAUD*16*2^ACC_W/CLK_FREQ).
- tick = carry out of the accumulator, so one tick per 1/16 bit. Free-running, cleared by rst.

TX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
- Transfer occurs when tx_valid && tx_ready. tx_data is latched at that edge. tx_ready drops the next cycle and stays 0 until STOP completes.
- Each state lasts 16 ticks. DATA lasts DATA_BITS*16 ticks, sending bit 0 first. STOP lasts STOP_BITS*16 ticks.
- The start bit begins at the first tick after the transfer.
- tx_ready returns 1 in the cycle after the last stop tick. A back-to-back transfer in that cycle produces no extra idle bit.
- txd is registered: START=0, DATA=shift[0], PARITY=computed bit, STOP/IDLE=1.

RX synchroniser and filter:
- rxd passes through a 2-flop synchroniser clocked every clk.
- A 2-bit saturating majority filter, updated on tick, produces rx_bit. Its reset value is 1.

RX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
- IDLE: rx_bit==0 enters START and clears the 4-bit sample counter.
- START: at count 7 (mid-bit), rx_bit==1 is a false start and returns to IDLE with no rx_valid. Otherwise the counter wraps and the FSM moves to DATA.
- Every later bit is sampled at counter==7 of each 16-tick bit period. Data bits shift in LSB first.
- STOP sample:
  - Load rx_data.
  - rx_frame_err = ~rx_bit.
  - rx_parity_err = computed mismatch.
  - Pulse rx_valid for exactly 1 clk.
  - Go to IDLE immediately (mid-stop-bit), so a following start edge is caught.
- Frame error with the line held low (break): return to IDLE, then wait for rx_bit==1 before a new start is accepted.

rx_idle:
- Counter in tick units, cleared whenever the RX FSM is not IDLE or rx_bit==0.
- Saturates at IDLE_BITS*16 ticks; rx_idle = saturated.
- rx_idle is 0 after reset until the line has been high for IDLE_BITS bit times.

General:
- TX and RX are fully independent. Simultaneous TX transfer and rx_valid pulse need no arbitration.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - TX inserts a parity bit after the data: even = ^data, odd = ~^data (PARITY_ODD selects).
  - RX samples a parity bit and sets rx_parity_err on mismatch.
  - Frame length = 1 + DATA_BITS + 1 + STOP_BITS.
- Undefined:
  - No parity state in either FSM.
  - rx_parity_err is tied 0.
  - PARITY_ODD is ignored.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=100000, so one tick per clk and 16 clk per bit.
1. Reset, then tx_valid with tx_data=8'hA5, defaults -> txd: start 0 for 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then stop 1. tx_ready=0 for exactly 160 clk, then 1.
2. txd looped to rxd, send 8'h3C then 8'hC3 back-to-back -> two rx_valid pulses 160 clk apart, rx_data=3C then C3, both error flags 0.
3. rxd driven: start, data 8'h55, stop bit 0 -> rx_valid with rx_data=55 and rx_frame_err=1. rxd held low 40 bit times -> no further rx_valid until rxd returns high.
4. rxd low glitch of 4 clk while idle -> no rx_valid; FSM returns to IDLE by clk 8 after the glitch.
5. UART_PARITY_EN, PARITY_ODD=0, DATA_BITS=7, send 7'h41 -> parity bit 0. Inject frame with parity 1 -> rx_parity_err=1, rx_frame_err=0.
6. Assert rst at clk 50 of a TX frame -> txd=1 and tx_ready=1 the next cycle. rx_idle=0, then rises after 256 clk of rxd high.

Source files
------------

// File: rtl/uart_core.sv
// uart_core: full-duplex UART (TX + RX) sharing one 16x oversampling tick generator.
// Define UART_PARITY_EN to add a parity bit to both directions (PARITY_ODD selects odd).
module uart_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int IDLE_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_idle
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParams
        $error("uart_core: illegal parameter combination");
    end

    typedef enum logic [2:0] {Idle, Start, Data, Parity, Stop} UartState;

    // Phase accumulator: INC is one bit wider so an exact 16x ratio carries every clk
    localparam int ACC_W = $clog2(CLK_FREQ / BAUD) + 8;
    localparam logic [63:0] INC64 =
        (((64'(BAUD) * 64'd16) << ACC_W) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
    localparam logic [ACC_W:0] INC = INC64[ACC_W:0];
    localparam int IDLE_TICKS = IDLE_BITS * 16;
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   accSum;
    logic             tick;

    assign accSum = {1'b0, acc} + INC;
    assign tick   = accSum[ACC_W];

    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else     acc <= accSum[ACC_W-1:0];
    end

    // ---------------- transmitter ----------------
    UartState               txState, txNext;
    logic [3:0]             txTickCnt, txBitCnt;
    logic [DATA_BITS-1:0]   txShift;
    logic                   txLevel, txBitEnd;
`ifdef UART_PARITY_EN
    logic                   txParityBit;
`endif

    assign txBitEnd = tick && (txTickCnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) txState <= Idle;
        else     txState <= txNext;
    end

    always_comb begin
        txNext = txState;
        case (txState)
            Idle:  if (tx_valid) txNext = Start;
            Start: if (txBitEnd) txNext = Data;
`ifdef UART_PARITY_EN
            Data:   if (txBitEnd && txBitCnt == 4'(DATA_BITS - 1)) txNext = Parity;
            Parity: if (txBitEnd) txNext = Stop;
`else
            Data:  if (txBitEnd && txBitCnt == 4'(DATA_BITS - 1)) txNext = Stop;
`endif
            Stop:  if (txBitEnd && txBitCnt == 4'(STOP_BITS - 1)) txNext = Idle;
            default: txNext = Idle;
        endcase
    end

    always_comb begin
        txLevel  = 1'b1;
        tx_ready = 1'b0;
        case (txState)
            Idle:   tx_ready = 1'b1;
            Start:  txLevel  = 1'b0;
            Data:   txLevel  = txShift[0];
`ifdef UART_PARITY_EN
            Parity: txLevel  = txParityBit;
`endif
            default: ;
        endcase
    end

    // txBitCnt counts bits within the current state and restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            txd       <= 1'b1;
            txTickCnt <= '0;
            txBitCnt  <= '0;
            txShift   <= '0;
`ifdef UART_PARITY_EN
            txParityBit <= 1'b0;
`endif
        end else begin
            txd <= txLevel;
            if (txState == Idle) begin
                txTickCnt <= '0;
                txBitCnt  <= '0;
                if (tx_valid) begin
                    txShift <= tx_data;
`ifdef UART_PARITY_EN
                    txParityBit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end else if (tick) begin
                txTickCnt <= txTickCnt + 4'd1;
                if (txTickCnt == 4'd15) begin
                    if (txNext != txState) txBitCnt <= '0;
                    else                   txBitCnt <= txBitCnt + 4'd1;
                    if (txState == Data) txShift <= txShift >> 1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    UartState               rxState, rxNext;
    logic                   rxMeta, rxSync, rxBit, rxBreak;
    logic [1:0]             rxFilt;
    logic [3:0]             rxTickCnt, rxBitCnt;
    logic [DATA_BITS-1:0]   rxShift;
    logic                   rxMid, rxEnd, rxSampleData, rxSampleStop;
    logic [IDLE_W-1:0]      idleCnt;
`ifdef UART_PARITY_EN
    logic                   rxParityBit, rxSampleParity;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxFilt <= 2'b11;
        end else begin
            rxMeta <= rxd;
            rxSync <= rxMeta;
            if (tick) begin
                if (rxSync && rxFilt != 2'b11)       rxFilt <= rxFilt + 2'd1;
                else if (!rxSync && rxFilt != 2'b00) rxFilt <= rxFilt - 2'd1;
            end
        end
    end

    assign rxBit = rxFilt[1];
    assign rxMid = tick && (rxTickCnt == 4'd7);
    assign rxEnd = tick && (rxTickCnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) rxState <= Idle;
        else     rxState <= rxNext;
    end

    // After a break, rxBreak keeps the FSM in Idle until the line has gone high again
    always_comb begin
        rxNext = rxState;
        case (rxState)
            Idle:  if (!rxBit && !rxBreak) rxNext = Start;
            Start: if (rxMid && rxBit) rxNext = Idle;
                   else if (rxEnd)     rxNext = Data;
`ifdef UART_PARITY_EN
            Data:   if (rxEnd && rxBitCnt == 4'(DATA_BITS)) rxNext = Parity;
            Parity: if (rxEnd) rxNext = Stop;
`else
            Data:  if (rxEnd && rxBitCnt == 4'(DATA_BITS)) rxNext = Stop;
`endif
            Stop:  if (rxMid) rxNext = Idle;
            default: rxNext = Idle;
        endcase
    end

    always_comb begin
        rxSampleData = (rxState == Data) && rxMid;
        rxSampleStop = (rxState == Stop) && rxMid;
`ifdef UART_PARITY_EN
        rxSampleParity = (rxState == Parity) && rxMid;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxTickCnt    <= '0;
            rxBitCnt     <= '0;
            rxShift      <= '0;
            rxBreak      <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rxParityBit   <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (rxState == Idle) begin
                rxTickCnt <= '0;
                rxBitCnt  <= '0;
            end else if (tick) begin
                rxTickCnt <= rxTickCnt + 4'd1;
            end
            if (rxSampleData) begin
                rxShift  <= {rxBit, rxShift[DATA_BITS-1:1]};
                rxBitCnt <= rxBitCnt + 4'd1;
            end
`ifdef UART_PARITY_EN
            if (rxSampleParity) rxParityBit <= rxBit;
`endif
            if (rxSampleStop) begin
                rx_valid     <= 1'b1;
                rx_data      <= rxShift;
                rx_frame_err <= ~rxBit;
`ifdef UART_PARITY_EN
                rx_parity_err <= (^rxShift) ^ rxParityBit ^ (PARITY_ODD != 0);
`endif
            end
            if (rxSampleStop && !rxBit) rxBreak <= 1'b1;
            else if (rxBit)             rxBreak <= 1'b0;
        end
    end

`ifndef UART_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || rxState != Idle || !rxBit) idleCnt <= '0;
        else if (tick && idleCnt != IDLE_W'(IDLE_TICKS)) idleCnt <= idleCnt + 1'b1;
    end

    assign rx_idle = (idleCnt == IDLE_W'(IDLE_TICKS));

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed tests for uart_core with an RX scoreboard fed by the stimulus.
// Build with UART_PARITY_EN defined to also run the 7-bit even-parity scenario.
module tb_uart_core;

`ifdef UART_PARITY_EN
    localparam int DW  = 7;
    localparam int PAR = 1;
`else
    localparam int DW  = 8;
    localparam int PAR = 0;
`endif
    localparam int NB = 1 + DW + PAR + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          ferr;
        logic          perr;
    } RxExp;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          txd;
    logic          rxd;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          rx_idle;
    logic          loopback;
    logic          rxDrive;

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   rxValidCount = 0;
    int   lastValidCycle = 0;
    int   prevValidCycle = 0;
    RxExp rxExp[$];
    RxExp entry;

    assign rxd = loopback ? txd : rxDrive;

    uart_core #(
        .CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(DW),
        .STOP_BITS(1), .PARITY_ODD(0), .IDLE_BITS(16)
    ) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .txd(txd), .rxd(rxd), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .rx_idle(rx_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic forcedFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: bound expired, required event never seen", name);
    endtask

    task automatic tickClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxValidCount++;
            prevValidCycle = lastValidCycle;
            lastValidCycle = cycle;
            if (rxExp.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rxUnexpected: got pulse data 0x%0h, expected no pulse", rx_data);
            end else begin
                entry = rxExp.pop_front();
                checkOutput("rxData", 32'(rx_data), 32'(entry.data));
                checkOutput("rxFrameErr", 32'(rx_frame_err), 32'(entry.ferr));
                checkOutput("rxParityErr", 32'(rx_parity_err), 32'(entry.perr));
            end
        end
    end

    function automatic logic expTxBit(input logic [DW-1:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
`ifdef UART_PARITY_EN
        if (b == DW + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Leaves tx_valid high; returns one cycle after the transfer edge
    task automatic sendTx(input logic [DW-1:0] d, input bit expectRx);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (tx_ready !== 1'b1 && n < 1000) begin
            tickClk(1);
            n++;
        end
        if (n >= 1000) forcedFail("txReadyWait");
        if (expectRx) rxExp.push_back('{d, 1'b0, 1'b0});
        tickClk(1);
    endtask

    task automatic checkTxFrame(input logic [DW-1:0] d);
        int lowCnt = 0;
        for (int i = 0; i < 16 * NB + 40; i++) begin
            if (tx_ready === 1'b0) lowCnt++;
            if (i % 16 == 8 && i / 16 < NB)
                checkOutput($sformatf("txdBit%0d", i / 16), 32'(txd), 32'(expTxBit(d, i / 16)));
            tickClk(1);
        end
        checkOutput("txReadyLowClks", 32'(lowCnt), 32'(16 * NB));
        checkOutput("txReadyBack", 32'(tx_ready), 32'd1);
    endtask

    task automatic injectFrame(input logic [DW-1:0] d, input bit badParity, input bit stopBit);
        rxDrive = 1'b0;
        tickClk(16);
        for (int b = 0; b < DW; b++) begin
            rxDrive = d[b];
            tickClk(16);
        end
`ifdef UART_PARITY_EN
        rxDrive = (^d) ^ badParity;
        tickClk(16);
`else
        if (badParity) $display("[TB] note: parity ignored in this build");
`endif
        rxDrive = stopBit;
        tickClk(16);
    endtask

    task automatic waitRxDrain(input int budget);
        int n = 0;
        while (rxExp.size() != 0 && n < budget) begin
            tickClk(1);
            n++;
        end
        checkOutput("rxPending", 32'(rxExp.size()), 32'd0);
    endtask

    task automatic applyStimulus(input int testId);
        int vc;
        int gap;
        case (testId)
            0: begin
                tickClk(3);
                checkOutput("rstTxReady", 32'(tx_ready), 32'd1);
                checkOutput("rstTxd", 32'(txd), 32'd1);
                checkOutput("rstRxValid", 32'(rx_valid), 32'd0);
                checkOutput("rstRxData", 32'(rx_data), 32'd0);
                checkOutput("rstFrameErr", 32'(rx_frame_err), 32'd0);
                checkOutput("rstParityErr", 32'(rx_parity_err), 32'd0);
                checkOutput("rstRxIdle", 32'(rx_idle), 32'd0);
                rst = 1'b0;
                tickClk(4);
            end
            1: begin
                $display("[TB] single TX frame");
                sendTx(DW'(8'hA5), 1'b0);
                tx_valid = 1'b0;
                checkTxFrame(DW'(8'hA5));
            end
            2: begin
                $display("[TB] loopback back-to-back");
                loopback = 1'b1;
                sendTx(DW'(8'h3C), 1'b1);
                sendTx(DW'(8'hC3), 1'b1);
                tx_valid = 1'b0;
                waitRxDrain(2 * 16 * NB + 200);
                // the one tx_ready cycle between frames may add a single clk
                gap = lastValidCycle - prevValidCycle;
                checks++;
                if (gap != 16 * NB && gap != 16 * NB + 1) begin
                    failures++;
                    $display("[TB] FAIL rxPulseGap: got %0d expected %0d or %0d", gap, 16 * NB, 16 * NB + 1);
                end
                tickClk(20);
                loopback = 1'b0;
            end
            3: begin
                $display("[TB] frame error and break");
                rxDrive = 1'b1;
                tickClk(20);
                rxExp.push_back('{DW'(8'h55), 1'b1, 1'b0});
                injectFrame(DW'(8'h55), 1'b0, 1'b0);
                vc = rxValidCount;
                tickClk(40 * 16);
                checkOutput("breakPulses", 32'(rxValidCount - vc), 32'd0);
                waitRxDrain(50);
                rxDrive = 1'b1;
                tickClk(32);
                rxExp.push_back('{DW'(8'h12), 1'b0, 1'b0});
                injectFrame(DW'(8'h12), 1'b0, 1'b1);
                rxDrive = 1'b1;
                waitRxDrain(50);
            end
            4: begin
                $display("[TB] start glitch rejection");
                vc = rxValidCount;
                rxDrive = 1'b0;
                tickClk(4);
                rxDrive = 1'b1;
                tickClk(200);
                checkOutput("glitchPulses", 32'(rxValidCount - vc), 32'd0);
                rxDrive = 1'b0;
                tickClk(4);
                rxDrive = 1'b1;
                tickClk(8);
                rxExp.push_back('{DW'(8'h81), 1'b0, 1'b0});
                injectFrame(DW'(8'h81), 1'b0, 1'b1);
                rxDrive = 1'b1;
                waitRxDrain(50);
                checkOutput("glitchThenFrame", 32'(rxValidCount - vc), 32'd1);
            end
            5: begin
`ifdef UART_PARITY_EN
                $display("[TB] parity");
                sendTx(7'h41, 1'b0);
                tx_valid = 1'b0;
                checkTxFrame(7'h41);
                rxExp.push_back('{7'h41, 1'b0, 1'b1});
                injectFrame(7'h41, 1'b1, 1'b1);
                rxDrive = 1'b1;
                waitRxDrain(50);
`endif
            end
            6: begin
                $display("[TB] reset mid-frame and idle detect");
                rxDrive = 1'b1;
                tickClk(300);
                checkOutput("rxIdleBefore", 32'(rx_idle), 32'd1);
                sendTx('0, 1'b0);
                tx_valid = 1'b0;
                tickClk(49);
                checkOutput("txdMidFrame", 32'(txd), 32'd0);
                rst = 1'b1;
                tickClk(1);
                checkOutput("abortTxd", 32'(txd), 32'd1);
                checkOutput("abortTxReady", 32'(tx_ready), 32'd1);
                checkOutput("abortRxIdle", 32'(rx_idle), 32'd0);
                rst = 1'b0;
                tickClk(240);
                checkOutput("rxIdleEarly", 32'(rx_idle), 32'd0);
                tickClk(30);
                checkOutput("rxIdleSet", 32'(rx_idle), 32'd1);
            end
            default: ;
        endcase
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        rxDrive  = 1'b1;
        loopback = 1'b0;
        for (int t = 0; t <= 6; t++) applyStimulus(t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
